// File: rtl/message_display_ctrl.sv
// Seven-segment message controller: latches a request, selects one of a few
// fixed letter messages and presents it static, blinking or scrolling.
module message_display_ctrl #(
    parameter int unsigned NUM_DIGITS  = 6,
    parameter int unsigned TICK_DIV    = 12500000,
    parameter int unsigned BLINK_TICKS = 2
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [2:0]              Mode,
    input  logic                    IdOk,
    input  logic                    PswdOk,
    input  logic                    Update,
    output logic                    Ready,
    output logic [NUM_DIGITS*5-1:0] DigitCodes,
    output logic                    Blanked
);

    localparam int unsigned MSG_LEN   = 9;
    localparam int unsigned DW        = NUM_DIGITS * 5;
    localparam int unsigned TW        = $clog2(TICK_DIV);
    localparam int unsigned BW        = $clog2(BLINK_TICKS + 1);
    localparam int unsigned OFFW      = $clog2(MSG_LEN + NUM_DIGITS);
    localparam int unsigned OFF_MAX   = MSG_LEN + NUM_DIGITS - 1;
    localparam int unsigned PW        = OFFW + 1;
    localparam bit          DO_SCROLL = (MSG_LEN > NUM_DIGITS);

    localparam logic [4:0] L_BL = 5'b00000;
    localparam logic [4:0] L_A  = 5'b00001;
    localparam logic [4:0] L_C  = 5'b00011;
    localparam logic [4:0] L_D  = 5'b00100;
    localparam logic [4:0] L_F  = 5'b00110;
    localparam logic [4:0] L_I  = 5'b01001;
    localparam logic [4:0] L_L  = 5'b01011;
    localparam logic [4:0] L_O  = 5'b01101;
    localparam logic [4:0] L_P  = 5'b01110;
    localparam logic [4:0] L_S  = 5'b10001;
    localparam logic [4:0] L_U  = 5'b10011;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STATIC,
        SCROLL,
        BLINK
    } state_t;

    state_t                        state, stateNext, msgState;
    logic [TW-1:0]                 tickCnt, tickCntNext;
    logic [OFFW-1:0]               offset, offsetNext;
    logic [BW-1:0]                 blinkCnt, blinkCntNext;
    logic                          phaseOn, phaseOnNext;
    logic [2:0]                    modeLat, modeLatNext;
    logic                          idOkLat, idOkLatNext;
    logic                          pswdOkLat, pswdOkLatNext;
    logic [DW-1:0]                 digitsNext;
    logic                          blankedNext;
    logic                          readyNext;
    logic [MSG_LEN-1:0][4:0]       layout;
    logic [DW-1:0]                 frame;
    logic                          accept;
    logic                          tick;

    assign accept = Update && Ready;
    assign tick   = (tickCnt == TW'(TICK_DIV - 1));

    // Message characters at their absolute digit positions (scroll uses the same array)
    always_comb begin
        layout   = '0;
        msgState = STATIC;
        if (modeLat == 3'b011) begin
            layout[0] = L_S; layout[1] = L_U; layout[2] = L_C; layout[3] = L_C;
        end else if (modeLat == 3'b100) begin
            layout[0] = L_F; layout[1] = L_A; layout[2] = L_I; layout[3] = L_L;
            msgState  = BLINK;
        end else if (modeLat == 3'b101) begin
            layout[0] = L_F; layout[1] = L_A; layout[2] = L_I; layout[3] = L_L;
            layout[4] = L_BL;
            layout[5] = L_P; layout[6] = L_S; layout[7] = L_C; layout[8] = L_O;
            msgState  = DO_SCROLL ? SCROLL : STATIC;
        end else if (!idOkLat) begin
            layout[2] = L_I; layout[3] = L_D;
        end else if (!pswdOkLat) begin
            layout[1] = L_P; layout[2] = L_S; layout[3] = L_C; layout[4] = L_O;
        end
    end

    // Scroll offset kept separate so the frame below can be built from its next value
    always_comb begin
        offsetNext = offset;
        if (accept || state == LOAD) begin
            offsetNext = '0;
        end else if (state == SCROLL && tick) begin
            offsetNext = (offset == OFFW'(OFF_MAX)) ? '0 : offset + OFFW'(1);
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : gDigit
        logic [PW-1:0] pos;
        assign pos = PW'(g) + PW'(offsetNext);
        assign frame[g*5 +: 5] = (pos < PW'(MSG_LEN)) ? layout[pos[3:0]] : 5'd0;
    end

    always_comb begin
        stateNext     = state;
        tickCntNext   = tick ? '0 : tickCnt + TW'(1);
        blinkCntNext  = blinkCnt;
        phaseOnNext   = phaseOn;
        modeLatNext   = modeLat;
        idOkLatNext   = idOkLat;
        pswdOkLatNext = pswdOkLat;
        digitsNext    = DigitCodes;
        blankedNext   = 1'b0;
        readyNext     = 1'b1;

        if (accept) begin
            stateNext     = LOAD;
            tickCntNext   = '0;
            blinkCntNext  = '0;
            phaseOnNext   = 1'b1;
            modeLatNext   = Mode;
            idOkLatNext   = IdOk;
            pswdOkLatNext = PswdOk;
            readyNext     = 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    stateNext    = msgState;
                    tickCntNext  = '0;
                    blinkCntNext = '0;
                    phaseOnNext  = 1'b1;
                    digitsNext   = frame;
                end
                SCROLL: begin
                    digitsNext = frame;
                end
                BLINK: begin
                    if (tick) begin
                        if (blinkCnt == BW'(BLINK_TICKS - 1)) begin
                            blinkCntNext = '0;
                            phaseOnNext  = !phaseOn;
                        end else begin
                            blinkCntNext = blinkCnt + BW'(1);
                        end
                    end
                    digitsNext  = phaseOnNext ? frame : '0;
                    blankedNext = !phaseOnNext;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state      <= IDLE;
            tickCnt    <= '0;
            offset     <= '0;
            blinkCnt   <= '0;
            phaseOn    <= 1'b1;
            modeLat    <= 3'b000;
            idOkLat    <= 1'b0;
            pswdOkLat  <= 1'b0;
            DigitCodes <= '0;
            Blanked    <= 1'b0;
            Ready      <= 1'b1;
        end else begin
            state      <= stateNext;
            tickCnt    <= tickCntNext;
            offset     <= offsetNext;
            blinkCnt   <= blinkCntNext;
            phaseOn    <= phaseOnNext;
            modeLat    <= modeLatNext;
            idOkLat    <= idOkLatNext;
            pswdOkLat  <= pswdOkLatNext;
            DigitCodes <= digitsNext;
            Blanked    <= blankedNext;
            Ready      <= readyNext;
        end
    end

endmodule

// File: doc/message_display_ctrl.md
MESSAGE_DISPLAY_CTRL -- requirements
Module: message_display_ctrl

Parameters
REQ-001 NUM_DIGITS, default 6: number of seven-segment digits driven; legal range 6..10.
REQ-002 TICK_DIV, default 12500000: Clk cycles per display tick; minimum 2.
REQ-003 BLINK_TICKS, default 2: ticks per blink half-period; minimum 1.

Interface
REQ-004 Clk  input  1  system clock; all state changes on its rising edge.
REQ-005 Rst  input  1  asynchronous reset, active-low.
REQ-006 Mode  input  3  message mode select; sampled only on an accepted Update.
REQ-007 IdOk  input  1  ID-valid flag; sampled only on an accepted Update.
REQ-008 PswdOk  input  1  password-valid flag; sampled only on an accepted Update.
REQ-009 Update  input  1  single-cycle request to latch Mode/IdOk/PswdOk and load a new message.
REQ-010 Ready  output  1  high when Update is accepted.
REQ-011 DigitCodes  output  NUM_DIGITS*5  registered 5-bit letter code per digit; digit i at bits [5i+4:5i]; digit 0 leftmost.
REQ-012 Blanked  output  1  high during the off half of a blink.

Function
REQ-013 Letter codes SHALL be: blank 00000, A 00001, C 00011, D 00100, F 00110, I 01001, L 01011, O 01101, P 01110, S 10001, U 10011.
REQ-014 Message selection SHALL use the latched inputs with this priority:
- Mode=011 -> "SUCC" at digits 0-3, static.
- Mode=100 -> "FAIL" at digits 0-3, blinking.
- Mode=101 -> 9-char "FAIL PSCO" (char 4 blank), scrolling if 9 > NUM_DIGITS, otherwise static at digits 0-8.
- else IdOk=0 -> "ID" at digits 2-3, static.
- else PswdOk=0 -> "PSCO" at digits 1-4, static.
- else all blank, static.
REQ-015 Unused digit positions SHALL be 00000.
REQ-016 FSM states SHALL be IDLE, LOAD, STATIC, SCROLL and BLINK; Ready=1 in every state except LOAD.
REQ-017 Update sampled high while Ready=1 at edge N SHALL latch the inputs and enter LOAD; at edge N+1 DigitCodes SHALL show the first frame, TickCnt SHALL be 0, and the FSM SHALL enter the state for the selected message.
REQ-018 Update while Ready=0 SHALL be ignored and not queued.
REQ-019 TickCnt SHALL count 0..TICK_DIV-1 and wrap; a tick occurs on the cycle TickCnt=TICK_DIV-1.
REQ-020 SCROLL: offset SHALL start at 0 and increment once per tick; it wraps from 9+NUM_DIGITS-1 to 0.
REQ-021 SCROLL: digit j SHALL show message char offset+j when that index is below 9, otherwise blank.
REQ-022 BLINK SHALL start in the on phase and toggle phase every BLINK_TICKS ticks.
REQ-023 BLINK off phase: all DigitCodes=00000 and Blanked=1; on phase: Blanked=0.
REQ-024 Blanked SHALL be 0 in every state other than BLINK.
REQ-025 An accepted Update on the same edge as a tick SHALL take precedence; that tick has no effect on offset or blink phase.
REQ-026 STATIC and IDLE SHALL hold DigitCodes constant.

Reset
REQ-027 Rst low SHALL immediately force: state IDLE, DigitCodes all 0, Blanked=0, Ready=1, TickCnt=0, offset=0, blink phase on, latched Mode=000, IdOk=0, PswdOk=0.
REQ-028 After Rst deasserts, the outputs SHALL stay blank until the first accepted Update.
REQ-029 Reset asserted mid-scroll or mid-blink SHALL abandon the message without completing the current frame.

Verification (NUM_DIGITS=6, TICK_DIV=4, BLINK_TICKS=2)
REQ-030 Reset release, no Update -> DigitCodes=0, Ready=1, Blanked=0 for 100 cycles.
REQ-031 Mode=011 with Update at edge N -> Ready=0 for one cycle; after edge N+1 digits 0-3 = 10001,10011,00011,00011 and digits 4-5 = 0.
REQ-032 Mode=100 Update -> FAIL (00110,00001,01001,01011) shown for 8 cycles, then 8 cycles all-zero with Blanked=1, repeating.
REQ-033 Mode=101 Update -> frame 0 = F,A,I,L,blank,P; after 1 tick digit 0 = 00001; after 15 ticks frame 0 repeats exactly.
REQ-034 Second Update in the LOAD cycle -> ignored; Update coincident with a tick -> new message at offset 0 with TickCnt=0.
REQ-035 Rst pulsed low mid-scroll -> DigitCodes=0 in the same cycle, with no clock edge required; Update after release -> normal load.
